// File: rtl/ltc_pkg.sv
// Shared types and constants for the nonce collection path: entry layout
// used between the capture/arbiter logic and the output FIFO.
package ltc_pkg;

    localparam int NONCE_W   = 32;
    localparam int CORE_ID_W = 4;

    typedef struct packed {
        logic [CORE_ID_W-1:0] core_id;
        logic [NONCE_W-1:0]   nonce;
    } nonce_entry_t;

    localparam int ENTRY_W = $bits(nonce_entry_t);

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// First-word-fall-through FIFO for tagged nonce entries. The head output
// holds the last entry seen once the FIFO drains or is flushed.
module nonce_fifo
    import ltc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   hash_clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [ENTRY_W-1:0]     push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [ENTRY_W-1:0]     head_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int AW = clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] last_q;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        cnt;
    logic               do_push;
    logic               do_pop;

    assign empty     = (cnt == '0);
    assign full      = (cnt == (AW+1)'(DEPTH));
    assign count     = cnt;
    assign head_data = empty ? last_q : mem[rd_ptr];

    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            last_q <= head_data;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (do_push && !do_pop) begin
                    cnt <= cnt + (AW+1)'(1);
                end else if (do_pop && !do_push) begin
                    cnt <= cnt - (AW+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge hash_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/nonce_collector.sv
// Captures golden-nonce strobes from the local hashcores, arbitrates them
// round-robin into a FIFO and presents the stream to the host link.
module nonce_collector
    import ltc_pkg::*;
#(
    parameter int LOCAL_MINERS = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 16
) (
    input  logic                             hash_clk,
    input  logic                             rst_n,
    input  logic [LOCAL_MINERS*NONCE_W-1:0]  golden_nonce_i,
    input  logic [LOCAL_MINERS-1:0]          golden_nonce_match,
    input  logic                             flush,
    output logic [NONCE_W-1:0]               out_nonce,
    output logic [CORE_ID_W-1:0]             out_core,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NONCE_W-1:0]               golden_nonce_out,
    output logic [clog2(FIFO_DEPTH):0]       fifo_count,
    output logic [CNT_W-1:0]                 overrun_count
);

    logic [LOCAL_MINERS-1:0] pending;
    logic [NONCE_W-1:0]      hold [LOCAL_MINERS];
    logic [CORE_ID_W-1:0]    rr_ptr;
    logic [CORE_ID_W-1:0]    rr_next;
    logic [CORE_ID_W-1:0]    grant_idx;
    logic                    grant_valid;
    logic [LOCAL_MINERS-1:0] granted;
    logic [LOCAL_MINERS-1:0] overrun;
    logic [4:0]              overrun_n;
    logic [CNT_W+4:0]        overrun_sum;
    logic [NONCE_W-1:0]      push_nonce;
    logic                    push_en;
    logic                    pop_en;
    logic                    fifo_full;
    logic                    fifo_empty;
    nonce_entry_t            push_entry;
    nonce_entry_t            head_entry;
    logic [ENTRY_W-1:0]      head_data;

    // Output handshake: an entry transfers on a rising edge where out_valid
    // and out_ready are both high; out_valid never depends on out_ready and
    // the head stays stable until it transfers. A flush cycle transfers nothing.
    assign pop_en  = out_valid && out_ready && !flush;
    assign push_en = grant_valid && !flush && (!fifo_full || pop_en);

    // Two passes: first from rr_ptr upward, then wrap to the low indices.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < LOCAL_MINERS; i++) begin
            if (!grant_valid && pending[i] && (CORE_ID_W'(i) >= rr_ptr)) begin
                grant_valid = 1'b1;
                grant_idx   = CORE_ID_W'(i);
            end
        end
        for (int i = 0; i < LOCAL_MINERS; i++) begin
            if (!grant_valid && pending[i]) begin
                grant_valid = 1'b1;
                grant_idx   = CORE_ID_W'(i);
            end
        end
    end

    assign rr_next = (grant_idx == CORE_ID_W'(LOCAL_MINERS-1)) ? '0
                                                                : grant_idx + CORE_ID_W'(1);

    always_comb begin
        push_nonce = '0;
        granted    = '0;
        overrun    = '0;
        overrun_n  = '0;
        for (int i = 0; i < LOCAL_MINERS; i++) begin
            if (grant_idx == CORE_ID_W'(i)) begin
                push_nonce = hold[i];
            end
            granted[i] = push_en && (grant_idx == CORE_ID_W'(i));
            // A granted core hands its old value to the FIFO, so a fresh match is not a loss.
            overrun[i] = golden_nonce_match[i] && pending[i] && !granted[i] && !flush;
            overrun_n  = overrun_n + 5'(overrun[i]);
        end
    end

    assign overrun_sum = {5'b0, overrun_count} + (CNT_W+5)'(overrun_n);

    assign push_entry.core_id = grant_idx;
    assign push_entry.nonce   = push_nonce;

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            pending          <= '0;
            rr_ptr           <= '0;
            golden_nonce_out <= '0;
            overrun_count    <= '0;
            for (int i = 0; i < LOCAL_MINERS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LOCAL_MINERS; i++) begin
                if (golden_nonce_match[i]) begin
                    hold[i] <= golden_nonce_i[i*NONCE_W +: NONCE_W];
                end
            end
            if (flush) begin
                pending <= golden_nonce_match;
            end else begin
                pending <= (pending & ~granted) | golden_nonce_match;
            end
            if (push_en) begin
                rr_ptr <= rr_next;
            end
            if (pop_en) begin
                golden_nonce_out <= head_entry.nonce;
            end
            if (|overrun) begin
                if (overrun_sum > {5'b0, {CNT_W{1'b1}}}) begin
                    overrun_count <= '1;
                end else begin
                    overrun_count <= overrun_sum[CNT_W-1:0];
                end
            end
        end
    end

    nonce_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .hash_clk  (hash_clk),
        .rst_n     (rst_n),
        .push      (push_en),
        .push_data (push_entry),
        .pop       (pop_en),
        .flush     (flush),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_entry = head_data;
    assign out_valid  = !fifo_empty;
    assign out_nonce  = head_entry.nonce;
    assign out_core   = head_entry.core_id;

endmodule

// File: doc/nonce_collector.md
Name: nonce_collector

Overview:
- Gathers golden-nonce results from LOCAL_MINERS hashcore instances and serialises them into one ordered stream.
- Each core's single-cycle match pulse is captured into a per-core holding register. A round-robin arbiter then pushes tagged entries into a small FIFO.
- The FIFO drains through a valid/ready handshake to the host-facing link (virtual wire probe or serial comms). Entries are lost only under explicitly counted overrun.

Parameters:
- LOCAL_MINERS, 4, number of hashcore instances served (1..16).
- FIFO_DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the overrun counter.

Ports:
- hash_clk  in  1  hashing clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- golden_nonce_i  in  LOCAL_MINERS*32  per-core nonce; core i occupies bits [(i+1)*32-1:i*32].
- golden_nonce_match  in  LOCAL_MINERS  per-core single-cycle match strobe.
- flush  in  1  new work loaded; discard all pending and queued nonces.
- out_nonce  out  32  nonce at FIFO head.
- out_core  out  4  originating core index at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- golden_nonce_out  out  32  last nonce accepted by the consumer; holds until the next accept.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.
- overrun_count  out  CNT_W  number of nonces lost; saturating.

Behaviour:
- Reset (async assert, sync release): pending flags 0, holding registers 0, FIFO empty, rr pointer 0, out_valid 0, out_nonce 0, out_core 0, golden_nonce_out 0, fifo_count 0, overrun_count 0.
- Capture: when golden_nonce_match[i]=1 at an edge, hold[i] <= nonce_i and pending[i] <= 1.
  - If pending[i] was already 1 and is not granted that same edge, the new nonce overwrites the old one and overrun_count increments.
- Arbiter: each cycle at most one grant.
  - Searches pending[] starting at index rr_ptr, wrapping modulo LOCAL_MINERS.
  - Grant allowed when FIFO not full, or when full and a pop occurs the same cycle.
  - On grant g: push {g, hold[g]}, clear pending[g], rr_ptr <= (g+1) mod LOCAL_MINERS.
  - Grant and a new match on the same core in the same cycle: the old value is pushed and the new one is captured with pending kept at 1. No overrun is counted.
- Latency: match at edge N gives out_valid=1 after edge N+1 when the FIFO is empty and no other core is pending.
- FIFO is first-word-fall-through:
  - out_nonce and out_core always reflect the head entry; they hold their last value when empty.
  - Pop occurs when out_valid && out_ready; on pop, golden_nonce_out <= out_nonce.
  - out_ready while empty has no effect.
- Full: pending flags simply wait. Drops occur only through overwrite, so nothing is ever dropped at the FIFO itself.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. fifo_count is exact from 0 to FIFO_DEPTH.
- Flush (synchronous, one cycle): clears all pending flags, empties the FIFO and suppresses any grant or pop that cycle.
  - rr_ptr, golden_nonce_out and overrun_count are kept.
  - A match in the flush cycle is still captured.
- overrun_count saturates at all-ones.
- Simultaneous matches on k cores: all are captured and drained over k consecutive cycles in round-robin order.

Decomposition:
- Shared package ltc_pkg:
  - constants NONCE_W=32 and CORE_ID_W=4;
  - a nonce_entry_t struct {core_id, nonce};
  - function clog2.
- Sub-module nonce_fifo: parameterised synchronous FWFT FIFO with push, pop, flush, full, empty and count.
- Capture registers and the round-robin arbiter live in the top module.

Test Plan:
- Single hit: LOCAL_MINERS=4, match[2] with nonce 0x0000318f, out_ready=1 → out_valid high one cycle after capture edge with out_core=2 and out_nonce=0x0000318f; then golden_nonce_out=0x0000318f; overrun_count=0.
- Simultaneous: match=4'b1011 with nonces 0xA0, 0xA1, 0xA3, rr_ptr=0, out_ready=1 → outputs appear in core order 0, 1, 3 on consecutive cycles.
- Fairness: hold cores 0 and 3 pending repeatedly with out_ready=1 → grants alternate 0, 3, 0, 3; neither core is starved.
- Backpressure/full: out_ready=0, inject 10 hits across cores → fifo_count=8 and the 2 extra hits stay pending; raise out_ready → all 10 drain in order with overrun_count=0.
- Overrun: out_ready=0 with FIFO full, core 1 matches 0x11 then 0x22 → overrun_count=1; core 1 later delivers 0x22.
- Flush and reset: FIFO holding 3 entries, pulse flush together with match[0]=0x55 → only 0x55 is delivered. Assert rst_n=0 mid-drain → every output clears immediately.
